// File: rtl/tdm_demux_1x16.sv
// ============================================================================
// Module   : tdm_demux_1x16
// Purpose  : Time-division 1-to-16 demultiplexer. Receive end of a serial
//            slot stream produced by a 16x1 mux with a rolling 4-bit select.
//            Deserializes one bit per accepted slot into a shadow word and
//            publishes complete frames atomically on Y_out.
// Ports    : clk         - rising-edge clock
//            rst         - synchronous, active-high reset
//            d_in        - serial slot data
//            d_valid     - d_in carries a slot this cycle (gaps allowed)
//            frame_start - marks the current valid bit as slot 0
//            sel_out     - index of the next slot expected
//            Y_out       - last complete frame, bit k = slot k
//            frame_done  - one-cycle pulse, Y_out has just been updated
//            frame_err   - one-cycle pulse, frame aborted or failed check
//            busy        - high while a frame is being received
// Options  : TDM_PARITY_EN - when defined, each frame carries one extra
//            even-parity slot after the last data slot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_demux_1x16 #(
    parameter int DATA_WIDTH = 16,
    parameter int SEL_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  d_in,
    input  logic                  d_valid,
    input  logic                  frame_start,
    output logic [SEL_WIDTH-1:0]  sel_out,
    output logic [DATA_WIDTH-1:0] Y_out,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic                  busy
);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_RECV   = 2'd1;
`ifdef TDM_PARITY_EN
    localparam logic [1:0] c_S_PARITY = 2'd2;
`endif

    localparam logic [SEL_WIDTH-1:0] c_LAST_SLOT = SEL_WIDTH'(DATA_WIDTH - 1);

    logic [1:0]            r_state;
    logic [SEL_WIDTH-1:0]  r_sel;
    logic [DATA_WIDTH-1:0] r_shadow;
    logic [DATA_WIDTH-1:0] r_y;
    logic                  r_done;
    logic                  r_err;

    logic [1:0]            w_state_nxt;
    logic [SEL_WIDTH-1:0]  w_sel_nxt;
    logic [DATA_WIDTH-1:0] w_shadow_nxt;
    logic [DATA_WIDTH-1:0] w_y_nxt;
    logic                  w_done_nxt;
    logic                  w_err_nxt;

    // State and output registers; everything visible at the ports is
    // registered so there is no combinational input-to-output path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_S_IDLE;
            r_sel    <= '0;
            r_shadow <= '0;
            r_y      <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_shadow <= w_shadow_nxt;
            r_y      <= w_y_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_shadow_nxt = r_shadow;
        w_y_nxt      = r_y;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;

        if (d_valid) begin
            if (frame_start) begin
                // A frame_start always (re)starts a frame; seen mid-frame it
                // aborts the partial frame, which is flagged as an error.
                if (r_state != c_S_IDLE) begin
                    w_err_nxt = 1'b1;
                end
                w_shadow_nxt[0] = d_in;
                w_sel_nxt       = SEL_WIDTH'(1);
                w_state_nxt     = c_S_RECV;
            end else begin
                case (r_state)
                    c_S_RECV: begin
                        w_shadow_nxt[r_sel] = d_in;
                        if (r_sel == c_LAST_SLOT) begin
                            w_sel_nxt = '0;
`ifdef TDM_PARITY_EN
                            w_state_nxt = c_S_PARITY;
`else
                            // Publish straight from the incoming bit so the
                            // next cycle can already start a new frame.
                            w_y_nxt     = {d_in, r_shadow[DATA_WIDTH-2:0]};
                            w_done_nxt  = 1'b1;
                            w_state_nxt = c_S_IDLE;
`endif
                        end else begin
                            w_sel_nxt = r_sel + SEL_WIDTH'(1);
                        end
                    end
`ifdef TDM_PARITY_EN
                    c_S_PARITY: begin
                        // Even parity over data bits plus the parity slot.
                        if ((^r_shadow ^ d_in) == 1'b0) begin
                            w_y_nxt    = r_shadow;
                            w_done_nxt = 1'b1;
                        end else begin
                            w_err_nxt  = 1'b1;
                        end
                        w_state_nxt = c_S_IDLE;
                    end
`endif
                    default: begin
                        // IDLE: stray valid bits are dropped silently.
                    end
                endcase
            end
        end
    end

    assign sel_out    = r_sel;
    assign Y_out      = r_y;
    assign frame_done = r_done;
    assign frame_err  = r_err;
    assign busy       = (r_state != c_S_IDLE);

endmodule

`default_nettype wire
